// File: rtl/parking_lot_sensor_gen_pkg.sv
// Shared definitions for the parking-lot two-beam sensor interface.
// Used by the stimulus generator (parking_lot_sensor_gen) and by the
// entry/exit detector on the receiving end, so both agree on state names
// and on the {a,b} sensor codes.
//   gen_state_t : generator sequence states
//   dir_t       : direction of the car being played back
//   SENS_*      : {a,b} codes (a = outer beam, b = inner beam)
package parking_lot_pkg;

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP, DONE} gen_state_t;
    typedef enum logic {ENTER, EXIT} dir_t;

    localparam logic [1:0] SENS_CLEAR = 2'b00;
    localparam logic [1:0] SENS_A     = 2'b10;
    localparam logic [1:0] SENS_AB    = 2'b11;
    localparam logic [1:0] SENS_B     = 2'b01;

    // Beam pattern for a state; exit is the mirror image of entry.
    function automatic logic [1:0] sens_code(gen_state_t s, dir_t d);
        case (s)
            PH1:     return (d == ENTER) ? SENS_A : SENS_B;
            PH2:     return SENS_AB;
            PH3:     return (d == ENTER) ? SENS_B : SENS_A;
            default: return SENS_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/parking_lot_sensor_gen_if.sv
// Request/sensor bundle between a requester (switches, bench) and the
// sensor generator.
//   start_enter, start_exit, dwell : requests and per-phase hold length
//   a, b                           : outer/inner beam blocked
//   busy, done                     : sequence in progress / end pulse
//   enter_cnt, exit_cnt            : completed sequence counters
// Modports: master = requester, slave = generator.
interface parking_lot_sensor_gen_if #(
    parameter int CW = 8,
    parameter int DW = 4
);
    logic          start_enter;
    logic          start_exit;
    logic [DW-1:0] dwell;
    logic          a;
    logic          b;
    logic          busy;
    logic          done;
    logic [CW-1:0] enter_cnt;
    logic [CW-1:0] exit_cnt;

    modport master (
        output start_enter, start_exit, dwell,
        input  a, b, busy, done, enter_cnt, exit_cnt
    );

    modport slave (
        input  start_enter, start_exit, dwell,
        output a, b, busy, done, enter_cnt, exit_cnt
    );
endinterface

// File: rtl/parking_lot_sensor_gen_dwell_timer.sv
// Phase dwell timer: loadable down-counter that holds at zero.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load (phase length minus one)
//   expire     : count is zero, i.e. this is the last cycle of the phase
module dwell_timer #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/parking_lot_sensor_gen.sv
// Two-beam photo-sensor waveform generator. Plays back the {a,b} pattern a
// car makes entering or exiting the lot, each phase held L = max(dwell,1)
// cycles, followed by an L-cycle clear gap and a one-cycle DONE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : parking_lot_sensor_gen_if.slave (requests in, sensor
//                code, status and completed-car counters out)
// All outputs decode from registered state only.
module parking_lot_sensor_gen
    import parking_lot_pkg::*;
#(
    parameter int CW = 8,
    parameter int DW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    parking_lot_sensor_gen_if.slave  bus
);

    gen_state_t    state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [DW-1:0] len_q, len_d;
    logic [CW-1:0] enter_cnt_q, enter_cnt_d;
    logic [CW-1:0] exit_cnt_q, exit_cnt_d;

    logic          tmr_load;
    logic [DW-1:0] tmr_load_val;
    logic          tmr_expire;
    logic [DW-1:0] dwell_eff;

    // A zero dwell would make phases vanish; clamp to one cycle.
    assign dwell_eff = (bus.dwell == '0) ? DW'(1) : bus.dwell;

    dwell_timer #(.DW(DW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        len_d        = len_q;
        tmr_load     = 1'b0;
        tmr_load_val = len_q - DW'(1);
        case (state_q)
            IDLE: begin
                // Entry wins a tie; the exit request is dropped, not queued.
                if (bus.start_enter || bus.start_exit) begin
                    state_d      = PH1;
                    dir_d        = bus.start_enter ? ENTER : EXIT;
                    len_d        = dwell_eff;
                    tmr_load     = 1'b1;
                    tmr_load_val = dwell_eff - DW'(1);
                end
            end
            PH1: if (tmr_expire) begin state_d = PH2;  tmr_load = 1'b1; end
            PH2: if (tmr_expire) begin state_d = PH3;  tmr_load = 1'b1; end
            PH3: if (tmr_expire) begin state_d = GAP;  tmr_load = 1'b1; end
            GAP: if (tmr_expire) begin state_d = DONE; tmr_load = 1'b1; end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters step on the edge leaving DONE, so an abandoned sequence
    // never counts.
    always_comb begin
        enter_cnt_d = enter_cnt_q;
        exit_cnt_d  = exit_cnt_q;
        if (state_q == DONE) begin
            if (dir_q == ENTER) enter_cnt_d = enter_cnt_q + CW'(1);
            else                exit_cnt_d  = exit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= ENTER;
            enter_cnt_q <= '0;
            exit_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            enter_cnt_q <= enter_cnt_d;
            exit_cnt_q  <= exit_cnt_d;
        end
    end

    // Phase length is only read while a sequence runs; it is always
    // written on start, so it carries no reset.
    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign {bus.a, bus.b} = sens_code(state_q, dir_q);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.enter_cnt  = enter_cnt_q;
    assign bus.exit_cnt   = exit_cnt_q;

endmodule

// File: tb/tb_parking_lot_sensor_gen.sv
// Directed bench for parking_lot_sensor_gen: one CW=8 instance for the
// main scenarios and loopback, one CW=2 instance for counter wrap.
// A small entry/exit detector watches the CW=8 instance's a/b lines.
module tb_parking_lot_sensor_gen;
    import parking_lot_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parking_lot_sensor_gen_if #(.CW(8), .DW(4)) bus1 ();
    parking_lot_sensor_gen_if #(.CW(2), .DW(4)) bus2 ();

    parking_lot_sensor_gen #(.CW(8), .DW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    parking_lot_sensor_gen #(.CW(2), .DW(4)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Receiver-side detector model: 10,11,01,00 = entry; 01,11,10,00 = exit.
    int ds = 0;
    int det_enter = 0;
    int det_exit = 0;
    always @(negedge clk) begin
        if (reset) begin
            ds <= 0; det_enter <= 0; det_exit <= 0;
        end else begin
            case (ds)
                0: if ({bus1.a, bus1.b} == SENS_A) ds <= 1;
                   else if ({bus1.a, bus1.b} == SENS_B) ds <= 4;
                1: if ({bus1.a, bus1.b} == SENS_AB) ds <= 2;
                   else if ({bus1.a, bus1.b} == SENS_CLEAR) ds <= 0;
                2: if ({bus1.a, bus1.b} == SENS_B) ds <= 3;
                3: if ({bus1.a, bus1.b} == SENS_CLEAR) begin det_enter <= det_enter + 1; ds <= 0; end
                4: if ({bus1.a, bus1.b} == SENS_AB) ds <= 5;
                   else if ({bus1.a, bus1.b} == SENS_CLEAR) ds <= 0;
                5: if ({bus1.a, bus1.b} == SENS_A) ds <= 6;
                6: if ({bus1.a, bus1.b} == SENS_CLEAR) begin det_exit <= det_exit + 1; ds <= 0; end
                default: ds <= 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus1.start_enter = 0; bus1.start_exit = 0; bus1.dwell = 0;
        bus2.start_enter = 0; bus2.start_exit = 0; bus2.dwell = 0;
        tick(); tick();
        checks++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000", {bus1.a, bus1.b, bus1.busy, bus1.done});
        end
        checks++;
        if (bus1.enter_cnt !== 8'd0 || bus1.exit_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus1.enter_cnt, bus1.exit_cnt);
        end
        checks++;
        if ({bus2.a, bus2.b, bus2.busy, bus2.done, bus2.enter_cnt} !== 6'b0) begin
            errors++; $display("FAIL reset_wrap_dut: got %b expected 000000", {bus2.a, bus2.b, bus2.busy, bus2.done, bus2.enter_cnt});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_entry_dwell2();
        logic [1:0] exp_ab [8];
        exp_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        bus1.dwell = 4'd2; bus1.start_enter = 1;
        tick();
        bus1.start_enter = 0;
        bus1.dwell = 4'd7;  // must not affect the running sequence
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== {exp_ab[i], 2'b10}) begin
                errors++; $display("FAIL entry_d2_cycle%0d: got %b expected %b", i, {bus1.a, bus1.b, bus1.busy, bus1.done}, {exp_ab[i], 2'b10});
            end
            tick();
        end
        checks++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== 4'b0011) begin
            errors++; $display("FAIL entry_d2_done: got %b expected 0011", {bus1.a, bus1.b, bus1.busy, bus1.done});
        end
        tick();
        checks++;
        if ({bus1.busy, bus1.done, bus1.enter_cnt, bus1.exit_cnt} !== {2'b00, 8'd1, 8'd0}) begin
            errors++; $display("FAIL entry_d2_after: busy=%b done=%b cnt=%0d/%0d expected 0 0 1/0", bus1.busy, bus1.done, bus1.enter_cnt, bus1.exit_cnt);
        end
    endtask

    task automatic test_exit_dwell0();
        logic [1:0] exp_ab [4];
        exp_ab = '{2'b01, 2'b11, 2'b10, 2'b00};
        bus1.dwell = 4'd0; bus1.start_exit = 1;
        tick();
        bus1.start_exit = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== {exp_ab[i], 2'b10}) begin
                errors++; $display("FAIL exit_d0_cycle%0d: got %b expected %b", i, {bus1.a, bus1.b, bus1.busy, bus1.done}, {exp_ab[i], 2'b10});
            end
            tick();
        end
        checks++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== 4'b0011) begin
            errors++; $display("FAIL exit_d0_done: got %b expected 0011", {bus1.a, bus1.b, bus1.busy, bus1.done});
        end
        tick();
        checks++;
        if ({bus1.busy, bus1.enter_cnt, bus1.exit_cnt} !== {1'b0, 8'd1, 8'd1}) begin
            errors++; $display("FAIL exit_d0_after: busy=%b cnt=%0d/%0d expected 0 1/1", bus1.busy, bus1.enter_cnt, bus1.exit_cnt);
        end
    endtask

    task automatic test_simultaneous();
        bus1.dwell = 4'd1; bus1.start_enter = 1; bus1.start_exit = 1;
        tick();
        bus1.start_enter = 0; bus1.start_exit = 0;
        checks++;
        if ({bus1.a, bus1.b} !== SENS_A) begin
            errors++; $display("FAIL simul_ph1: got %b expected 10", {bus1.a, bus1.b});
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (bus1.done !== 1'b1) begin
            errors++; $display("FAIL simul_done: got %b expected 1", bus1.done);
        end
        tick();
        checks++;
        if (bus1.enter_cnt !== 8'd2 || bus1.exit_cnt !== 8'd1) begin
            errors++; $display("FAIL simul_counts: got %0d/%0d expected 2/1", bus1.enter_cnt, bus1.exit_cnt);
        end
    endtask

    task automatic test_held_exit();
        bus1.dwell = 4'd1; bus1.start_exit = 1;
        tick();
        checks++;
        if ({bus1.a, bus1.b, bus1.busy} !== 3'b011) begin
            errors++; $display("FAIL held_ph1: got %b expected 011", {bus1.a, bus1.b, bus1.busy});
        end
        tick(); tick(); tick(); tick();
        checks++;
        if ({bus1.busy, bus1.done} !== 2'b11) begin
            errors++; $display("FAIL held_done: got %b expected 11", {bus1.busy, bus1.done});
        end
        tick();
        checks++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.exit_cnt} !== {3'b000, 8'd2}) begin
            errors++; $display("FAIL held_idle: ab=%b busy=%b exit_cnt=%0d expected 00 0 2", {bus1.a, bus1.b}, bus1.busy, bus1.exit_cnt);
        end
        tick();
        checks++;
        if ({bus1.a, bus1.b, bus1.busy} !== 3'b011) begin
            errors++; $display("FAIL held_restart: got %b expected 011", {bus1.a, bus1.b, bus1.busy});
        end
        bus1.start_exit = 0;
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (bus1.busy !== 1'b0 || bus1.exit_cnt !== 8'd3 || bus1.enter_cnt !== 8'd2) begin
            errors++; $display("FAIL held_counts: busy=%b cnt=%0d/%0d expected 0 2/3", bus1.busy, bus1.enter_cnt, bus1.exit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_ph [4];
        exp_ph = '{2'b10, 2'b11, 2'b01, 2'b00};
        bus1.dwell = 4'd3; bus1.start_enter = 1;
        tick();
        bus1.start_enter = 0;
        tick(); tick(); tick();
        checks++;
        if ({bus1.a, bus1.b} !== SENS_AB) begin
            errors++; $display("FAIL rmid_in_ph2: got %b expected 11", {bus1.a, bus1.b});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.enter_cnt, bus1.exit_cnt} !== 20'd0) begin
            errors++; $display("FAIL rmid_after_reset: ab=%b busy=%b cnt=%0d/%0d expected 00 0 0/0", {bus1.a, bus1.b}, bus1.busy, bus1.enter_cnt, bus1.exit_cnt);
        end
        bus1.start_enter = 1;
        tick();
        bus1.start_enter = 0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({bus1.a, bus1.b, bus1.busy, bus1.done} !== {exp_ph[i/3], 2'b10}) begin
                errors++; $display("FAIL rmid_replay_cycle%0d: got %b expected %b", i, {bus1.a, bus1.b, bus1.busy, bus1.done}, {exp_ph[i/3], 2'b10});
            end
            tick();
        end
        checks++;
        if (bus1.done !== 1'b1) begin
            errors++; $display("FAIL rmid_replay_done: got %b expected 1", bus1.done);
        end
        tick();
        checks++;
        if (bus1.enter_cnt !== 8'd1 || bus1.exit_cnt !== 8'd0) begin
            errors++; $display("FAIL rmid_counts: got %0d/%0d expected 1/0", bus1.enter_cnt, bus1.exit_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus2.dwell = 4'd1;
        for (int k = 0; k < 5; k++) begin
            bus2.start_enter = 1;
            tick();
            bus2.start_enter = 0;
            tick(); tick(); tick(); tick();
            tick();
            checks++;
            if (bus2.enter_cnt !== exp_cnt[k] || bus2.busy !== 1'b0) begin
                errors++; $display("FAIL wrap_seq%0d: cnt=%0d busy=%b expected %0d 0", k, bus2.enter_cnt, bus2.busy, exp_cnt[k]);
            end
        end
    endtask

    task automatic test_loopback();
        logic       dir_tab [5];
        logic [3:0] dw_tab [5];
        int         base_de, base_dx;
        logic [7:0] base_ec, base_xc;
        dir_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        dw_tab  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd2};
        base_de = det_enter; base_dx = det_exit;
        base_ec = bus1.enter_cnt; base_xc = bus1.exit_cnt;
        for (int s = 0; s < 5; s++) begin
            int n = 0;
            bus1.dwell = dw_tab[s];
            bus1.start_enter = ~dir_tab[s];
            bus1.start_exit  = dir_tab[s];
            tick();
            bus1.start_enter = 0; bus1.start_exit = 0;
            while (bus1.done !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 100) begin
                errors++; $display("FAIL loop_timeout_seq%0d: done not seen in %0d cycles, required within 100", s, n);
            end
            tick();
        end
        tick();
        checks++;
        if (det_enter - base_de !== 3 || det_exit - base_dx !== 2) begin
            errors++; $display("FAIL loop_detector: got %0d/%0d expected 3/2", det_enter - base_de, det_exit - base_dx);
        end
        checks++;
        if (8'(bus1.enter_cnt - base_ec) !== 8'd3 || 8'(bus1.exit_cnt - base_xc) !== 8'd2) begin
            errors++; $display("FAIL loop_counters: got %0d/%0d expected 3/2", 8'(bus1.enter_cnt - base_ec), 8'(bus1.exit_cnt - base_xc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_entry_dwell2();
        test_exit_dwell0();
        test_simultaneous();
        test_held_exit();
        test_reset_mid();
        test_wrap();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
